// File: rtl/tnn_sched_pkg.sv
// Shared types and helpers for the TNN core scheduler and its round-robin arbiter.
package tnn_sched_pkg;

   localparam int FEAT_W = 2;
   localparam int NFEAT  = 9;
   localparam int VEC_W  = FEAT_W * NFEAT;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESULT
   } state_t;

   // Index width that never collapses to zero bits, even for N <= 2.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tnn_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, searching upward from last+1 with wrap.
module rr_arbiter
   import tnn_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]               req,
   input  logic [clog2_min1(N)-1:0]   last,
   output logic [N-1:0]               grant
);

   localparam int LW = clog2_min1(N);

   logic          found;
   logic [LW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = LW'((int'(last) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tnn_core_scheduler.sv
// Time-shares one combinational TNN classifier core among NREQ requesters,
// with a settle window and a buffered, id-tagged result.
//
// state  | meaning
// IDLE   | arbitrate; a grant latches the winner's sample onto core_feat
// WAIT   | core_feat held, wait counter runs down; core_out sampled at count 1
// RESULT | res_valid high until the consumer takes the result
module tnn_core_scheduler #(
   parameter int NREQ        = 4,
   parameter int FEAT_W      = tnn_sched_pkg::FEAT_W,
   parameter int NFEAT       = tnn_sched_pkg::NFEAT,
   parameter int EVAL_CYCLES = 1,
   parameter int CNT_W       = 16,
   localparam int VEC_W      = FEAT_W * NFEAT,
   localparam int ID_W       = tnn_sched_pkg::clog2_min1(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*VEC_W-1:0]   req_feat,
   output logic [VEC_W-1:0]        core_feat,
   input  logic                    core_out,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ID_W-1:0]         res_id,
   output logic                    res_class,
   output logic                    busy,
   output logic [CNT_W-1:0]        eval_count
);

   localparam int CW = tnn_sched_pkg::clog2_min1(EVAL_CYCLES + 1);

   tnn_sched_pkg::state_t state, state_nx;

   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  win_id;
   logic [NREQ-1:0]  grant;
   logic [VEC_W-1:0] win_feat;
   logic [CW-1:0]    wait_cnt;
   logic             do_grant;
   logic             do_sample;
   logic             do_done;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (req_valid),
      .last  (last_grant),
      .grant (grant)
   );

   always_comb begin
      win_id   = '0;
      win_feat = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_id   = ID_W'(i);
            win_feat = req_feat[i*VEC_W +: VEC_W];
         end
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      do_grant  = 1'b0;
      do_sample = 1'b0;
      do_done   = 1'b0;
      case (state)
         tnn_sched_pkg::IDLE: begin
            req_ready = grant;
            if (|req_valid) begin
               do_grant = 1'b1;
               state_nx = tnn_sched_pkg::WAIT;
            end
         end
         tnn_sched_pkg::WAIT: begin
            if (wait_cnt == CW'(1)) begin
               do_sample = 1'b1;
               state_nx  = tnn_sched_pkg::RESULT;
            end
         end
         tnn_sched_pkg::RESULT: begin
            if (res_ready) begin
               do_done  = 1'b1;
               state_nx = tnn_sched_pkg::IDLE;
            end
         end
         default: state_nx = tnn_sched_pkg::IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= tnn_sched_pkg::IDLE;
      else     state <= state_nx;
   end

   // last_grant resets to NREQ-1 so requester 0 has first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_feat  <= '0;
         res_id     <= '0;
         res_class  <= 1'b0;
         last_grant <= ID_W'(NREQ - 1);
         wait_cnt   <= '0;
         eval_count <= '0;
      end else begin
         if (do_grant) begin
            core_feat  <= win_feat;
            res_id     <= win_id;
            last_grant <= win_id;
            wait_cnt   <= CW'(EVAL_CYCLES);
         end else if (state == tnn_sched_pkg::WAIT) begin
            wait_cnt <= wait_cnt - CW'(1);
         end
         if (do_sample)
            res_class <= core_out;
         if (do_done && (eval_count != '1))
            eval_count <= eval_count + CNT_W'(1);
      end
   end

   assign res_valid = (state == tnn_sched_pkg::RESULT);
   assign busy      = (state != tnn_sched_pkg::IDLE);

endmodule

// File: tb/tb_tnn_core_scheduler.sv
// Randomized and directed bench for tnn_core_scheduler against a transaction-level reference model.
module tb_tnn_core_scheduler;

   localparam int NREQ  = 4;
   localparam int VEC_W = 18;
   localparam int EVAL  = 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid, req_ready;
   logic [NREQ*VEC_W-1:0] req_feat;
   logic [VEC_W-1:0]      core_feat;
   logic                  core_out, res_valid, res_ready, res_class, busy;
   logic [1:0]            res_id;
   logic [15:0]           eval_count;

   logic [NREQ-1:0]       req_valid3, req_ready3;
   logic [NREQ*VEC_W-1:0] req_feat3;
   logic [VEC_W-1:0]      core_feat3;
   logic                  core_out3, res_valid3, res_ready3, res_class3, busy3, tog;
   logic [1:0]            res_id3;
   logic [1:0]            eval_count3;

   int total = 0, passed = 0, cyc = 0;

   // reference model state
   int               m_phase, m_last, m_id, m_acc, m_resseen, m_prev_acc, m_count;
   logic [VEC_W-1:0] m_feat;
   logic             m_cls;

   always #5 clk = ~clk;

   function automatic logic core_fn(input logic [VEC_W-1:0] v);
      int s = 0;
      for (int a = 0; a < 9; a++) s += int'(v[2*a +: 2]);
      return (s % 3) != 1;
   endfunction

   assign core_out  = core_fn(core_feat);
   assign core_out3 = core_fn(core_feat3) ^ tog;

   tnn_core_scheduler #(.NREQ(NREQ), .EVAL_CYCLES(EVAL), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_feat(req_feat),
      .core_feat(core_feat), .core_out(core_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_class(res_class), .busy(busy), .eval_count(eval_count));

   tnn_core_scheduler #(.NREQ(NREQ), .EVAL_CYCLES(3), .CNT_W(2)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_feat(req_feat3),
      .core_feat(core_feat3), .core_out(core_out3), .res_valid(res_valid3), .res_ready(res_ready3),
      .res_id(res_id3), .res_class(res_class3), .busy(busy3), .eval_count(eval_count3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_last = NREQ - 1; m_feat = '0; m_count = 0; m_prev_acc = -1;
   endtask

   // mode 0 random, 1 all valid + ready, 2 all valid + 5-cycle result stall, 3 drain
   task automatic run(input int mode, input int ncyc);
      int w;
      bit g;
      m_prev_acc = -1;
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         cyc++;
         w = (m_phase == 0) ? rr_pick(req_valid, m_last) : -1;
         check("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
         check("busy", 32'(busy), 32'(m_phase != 0));
         check("res_valid", 32'(res_valid), 32'(m_phase == 2));
         check("core_feat", 32'(core_feat), 32'(m_feat));
         check("eval_count", 32'(eval_count), 32'(m_count));
         if (m_phase == 2) begin
            check("res_id", 32'(res_id), 32'(m_id));
            check("res_class", 32'(res_class), 32'(m_cls));
         end
         g = 1'b0;
         case (m_phase)
            0: if (w >= 0) begin
                  if ((mode == 1 || mode == 2) && m_prev_acc >= 0)
                     check("accept_gap", 32'(cyc - m_prev_acc), (mode == 1) ? 32'd3 : 32'd8);
                  m_prev_acc = cyc;
                  m_feat = req_feat[w*VEC_W +: VEC_W];
                  m_id = w; m_last = w; m_acc = cyc; m_phase = 1; g = 1'b1;
               end
            1: if (cyc == m_acc + EVAL) begin
                  m_phase = 2; m_cls = core_fn(m_feat); m_resseen = 0;
               end
            default: begin
               m_resseen++;
               if (res_ready) begin
                  m_phase = 0;
                  if (m_count != 65535) m_count++;
               end
            end
         endcase
         @(posedge clk);
         #1;
         if (g) begin
            req_valid[w] = 1'b0;
            if (mode == 1 || mode == 2) begin
               req_valid[w] = 1'b1;
               req_feat[w*VEC_W +: VEC_W] = 18'($urandom);
            end
         end
         if (mode == 0) begin
            for (int i = 0; i < NREQ; i++)
               if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                  req_valid[i] = 1'b1;
                  req_feat[i*VEC_W +: VEC_W] = 18'($urandom);
               end
            res_ready = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            res_ready = (m_phase == 2) && (m_resseen >= 5);
         end else begin
            res_ready = 1'b1;
         end
      end
   endtask

   task automatic txn3(input int idx, input int exp_cnt);
      logic [VEC_W-1:0] f;
      f = 18'($urandom);
      @(posedge clk); #1;
      req_valid3 = '0; req_valid3[idx] = 1'b1; req_feat3[idx*VEC_W +: VEC_W] = f; tog = 1'b0;
      @(negedge clk); check("e3_ready", 32'(req_ready3), 32'd1 << idx);
      @(posedge clk); #1; req_valid3 = '0; tog = 1'b1;
      @(negedge clk); check("e3_feat", 32'(core_feat3), 32'(f)); check("e3_valid_t1", 32'(res_valid3), 0);
      @(posedge clk); #1; tog = 1'b1;
      @(negedge clk); check("e3_valid_t2", 32'(res_valid3), 0);
      @(posedge clk); #1; tog = 1'b0;
      @(negedge clk); check("e3_valid_t3", 32'(res_valid3), 0); check("e3_busy", 32'(busy3), 1);
      @(posedge clk); #1; tog = 1'b1; res_ready3 = 1'b1;
      @(negedge clk);
      check("e3_valid_t4", 32'(res_valid3), 1);
      check("e3_id", 32'(res_id3), 32'(idx));
      check("e3_class", 32'(res_class3), 32'(core_fn(f)));
      @(posedge clk); #1; res_ready3 = 1'b0; tog = 1'b0;
      @(negedge clk);
      check("e3_valid_after", 32'(res_valid3), 0);
      check("e3_count", 32'(eval_count3), 32'(exp_cnt));
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_feat = '0; res_ready = 1'b0;
      req_valid3 = '0; req_feat3 = '0; res_ready3 = 1'b0; tog = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_core_feat", 32'(core_feat), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_eval_count", 32'(eval_count), 0);
      check("rst_res_id", 32'(res_id), 0);
      check("rst_res_class", 32'(res_class), 0);

      // single requester, all-ones sample
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0001; req_feat[17:0] = 18'h3FFFF;
      @(negedge clk);
      check("t0_ready", 32'(req_ready), 32'h1);
      check("t0_core_feat", 32'(core_feat), 0);
      @(posedge clk); #1; req_valid = '0; res_ready = 1'b1;
      @(negedge clk);
      check("t1_core_feat", 32'(core_feat), 32'h3FFFF);
      check("t1_busy", 32'(busy), 1);
      check("t1_res_valid", 32'(res_valid), 0);
      check("t1_ready", 32'(req_ready), 0);
      @(negedge clk);
      check("t2_res_valid", 32'(res_valid), 1);
      check("t2_res_id", 32'(res_id), 0);
      check("t2_res_class", 32'(res_class), 1);
      @(negedge clk);
      check("t3_res_valid", 32'(res_valid), 0);
      check("t3_eval_count", 32'(eval_count), 1);
      model_reset();
      m_last = 0; m_feat = 18'h3FFFF; m_count = 1;

      @(posedge clk); #1;
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) req_feat[i*VEC_W +: VEC_W] = 18'($urandom);
      run(1, 30);
      run(2, 40);
      run(0, 400);
      run(3, 30);
      check("drain_valid", 32'(req_valid), 0);
      check("drain_busy", 32'(busy), 0);

      // reset while a sample is in flight
      @(posedge clk); #1;
      req_valid = 4'b0010; req_feat[35:18] = 18'($urandom); res_ready = 1'b1;
      @(negedge clk); check("pre_rst_ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1; req_valid = '0;
      @(negedge clk); check("pre_rst_busy", 32'(busy), 1);
      #1 rst = 1'b1;
      #1;
      check("arst_res_valid", 32'(res_valid), 0);
      check("arst_core_feat", 32'(core_feat), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_eval_count", 32'(eval_count), 0);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0101;
      req_feat[17:0] = 18'($urandom); req_feat[53:36] = 18'($urandom);
      #2;
      check("post_rst_grant", 32'(req_ready), 32'h1);
      check("post_rst_res_valid", 32'(res_valid), 0);
      model_reset();
      run(0, 60);

      // EVAL_CYCLES=3 sampling point and 2-bit counter saturation
      for (int k = 1; k <= 5; k++) txn3(int'($urandom_range(0, NREQ - 1)), (k > 3) ? 3 : k);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
